// File: rtl/breadboard_sweep.sv
// Truth-table sweeper: drives a 4-bit row index onto {w,x,y,z}, waits SETTLE cycles per row, then captures f.
// Optional BB_COMPARE_EN adds exp_data / mismatch_cnt for on-the-fly comparison against expected responses.
module breadboard_sweep #(
   parameter int SETTLE = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        w,
   output logic        x,
   output logic        y,
   output logic        z,
   input  logic [9:0]  f,
   output logic        busy,
   output logic        done,
   output logic        row_valid,
   output logic [3:0]  row_idx,
   output logic [9:0]  row_data,
   output logic [15:0] signature,
   input  logic [3:0]  rd_addr,
   output logic [9:0]  rd_data
`ifdef BB_COMPARE_EN
   ,
   input  logic [9:0]  exp_data,
   output logic [4:0]  mismatch_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

   state_t      r_state;
   logic [3:0]  r_idx;
   logic [3:0]  r_cnt;
   logic [3:0]  r_row;
   logic        r_busy;
   logic        r_done;
   logic        r_row_valid;
   logic [3:0]  r_row_idx;
   logic [9:0]  r_row_data;
   logic [15:0] r_sig;
   logic [9:0]  r_mem [16];
`ifdef BB_COMPARE_EN
   logic [4:0]  r_mis;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_row       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_row_valid <= 1'b0;
         r_row_idx   <= '0;
         r_row_data  <= '0;
         r_sig       <= '0;
         for (int i = 0; i < 16; i++) r_mem[i] <= '0;
`ifdef BB_COMPARE_EN
         r_mis       <= '0;
`endif
      end else begin
         r_row_valid <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx   <= '0;
                  r_row   <= '0;
                  r_cnt   <= '0;
                  r_sig   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SETTLE;
`ifdef BB_COMPARE_EN
                  r_mis   <= '0;
`endif
               end
            end
            S_SETTLE: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == LP_LAST) r_state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               r_mem[r_idx] <= f;
               r_row_valid  <= 1'b1;
               r_row_idx    <= r_idx;
               r_row_data   <= f;
               r_sig        <= {r_sig[14:0], r_sig[15]} ^ {6'b0, f};
`ifdef BB_COMPARE_EN
               if (f != exp_data && r_mis != 5'd16) r_mis <= r_mis + 5'd1;
`endif
               // Last row keeps {w,x,y,z} at 15; the index never wraps.
               if (r_idx != 4'd15) begin
                  r_idx   <= r_idx + 4'd1;
                  r_row   <= r_idx + 4'd1;
                  r_cnt   <= '0;
                  r_state <= S_SETTLE;
               end else begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign {w, x, y, z} = r_row;
   assign busy         = r_busy;
   assign done         = r_done;
   assign row_valid    = r_row_valid;
   assign row_idx      = r_row_idx;
   assign row_data     = r_row_data;
   assign signature    = r_sig;
   assign rd_data      = r_mem[rd_addr];
`ifdef BB_COMPARE_EN
   assign mismatch_cnt = r_mis;
`endif

endmodule

// File: tb/tb_breadboard_sweep.sv
// Bench for breadboard_sweep: scenario table of sweeps checked cycle-by-cycle against a timing/arithmetic model.
module tb_breadboard_sweep;

   localparam int SETTLE = 5;
   localparam int P      = SETTLE + 1;
   localparam int LAST   = 16 * P + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        w, x, y, z;
   logic [9:0]  f;
   logic [9:0]  f_tb;
   logic        loop;
   logic        busy, done, row_valid;
   logic [3:0]  row_idx;
   logic [9:0]  row_data;
   logic [15:0] signature;
   logic [3:0]  rd_addr;
   logic [9:0]  rd_data;
   logic [9:0]  val [16];
   logic        bad_en;

   int total = 0;
   int bad   = 0;

   assign f = loop ? {6'b0, w, x, y, z} : f_tb;

`ifdef BB_COMPARE_EN
   logic [9:0] exp_data;
   logic [4:0] mismatch_cnt;
   assign exp_data = (bad_en && {w, x, y, z} == 4'd3) ? 10'h000 : val[{w, x, y, z}];
`endif

   breadboard_sweep #(.SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start),
      .w(w), .x(x), .y(y), .z(z), .f(f),
      .busy(busy), .done(done), .row_valid(row_valid),
      .row_idx(row_idx), .row_data(row_data), .signature(signature),
      .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef BB_COMPARE_EN
      , .exp_data(exp_data), .mismatch_cnt(mismatch_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int mode;       // 0: f=0, 1: loopback, 2: random rows with noise while settling
      int restart_n;  // cycle at which a stray start is presented (-1 none)
      int rst_at;     // cycle at which reset aborts the sweep (-1 none)
      bit bad3;       // expected value for row 3 forced to 0
   } scen_t;

   typedef struct {
      logic [3:0] addr;
      logic [9:0] exp;
   } rd_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " wxyz"}, {28'b0, w, x, y, z}, 0);
      chk({tag, " busy"}, {31'b0, busy}, 0);
      chk({tag, " done"}, {31'b0, done}, 0);
      chk({tag, " row_valid"}, {31'b0, row_valid}, 0);
      chk({tag, " row_idx"}, {28'b0, row_idx}, 0);
      chk({tag, " row_data"}, {22'b0, row_data}, 0);
      chk({tag, " signature"}, {16'b0, signature}, 0);
`ifdef BB_COMPARE_EN
      chk({tag, " mismatch_cnt"}, {27'b0, mismatch_cnt}, 0);
`endif
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         #1;
         chk({tag, " rd_data"}, {22'b0, rd_data}, 0);
      end
   endtask

   task automatic run_sweep(input scen_t s);
      logic [15:0] sig_m;
      logic [9:0]  fs;
      int          exp_mis;
      int          k;
      bit          smp;
      int          row_m;
      for (int i = 0; i < 16; i++)
         val[i] = (s.mode == 0) ? 10'h0 : (s.mode == 1) ? 10'(i) : 10'($urandom);
      loop   = (s.mode == 1);
      bad_en = s.bad3;
      f_tb   = 10'h0;
      sig_m  = 16'h0;
      exp_mis = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("start busy", {31'b0, busy}, 1);
      chk("start wxyz", {28'b0, w, x, y, z}, 0);
      chk("start signature", {16'b0, signature}, 0);
`ifdef BB_COMPARE_EN
      chk("start mismatch clr", {27'b0, mismatch_cnt}, 0);
`endif
      for (int n = 1; n <= LAST + 6; n++) begin
         @(negedge clk);
         if (n == s.rst_at) begin
            rst = 1'b1;
            #1;
            chk_all_zero("midrst");
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
               @(posedge clk);
               #1;
               chk("after rst done", {31'b0, done}, 0);
               chk("after rst busy", {31'b0, busy}, 0);
            end
            return;
         end
         smp = (n % P == 0) && (n / P <= 16);
         k   = n / P - 1;
         if (s.mode == 2) f_tb = smp ? val[k] : 10'($urandom);
         start = (n == s.restart_n);
         @(posedge clk);
         #1 start = 1'b0;
         if (smp) begin
            fs    = val[k];
            sig_m = {sig_m[14:0], sig_m[15]} ^ {6'b0, fs};
            if (fs != ((s.bad3 && k == 3) ? 10'h0 : val[k]) && exp_mis < 16) exp_mis++;
            chk("row_valid", {31'b0, row_valid}, 1);
            chk("row_idx", {28'b0, row_idx}, 32'(k));
            chk("row_data", {22'b0, row_data}, {22'b0, fs});
            chk("signature", {16'b0, signature}, {16'b0, sig_m});
         end else begin
            chk("row_valid idle", {31'b0, row_valid}, 0);
         end
         row_m = (n / P > 15) ? 15 : n / P;
         chk("done", {31'b0, done}, (n == LAST) ? 1 : 0);
         chk("busy", {31'b0, busy}, (n < LAST) ? 1 : 0);
         chk("wxyz", {28'b0, w, x, y, z}, 32'(row_m));
      end
      chk("hold row_idx", {28'b0, row_idx}, 15);
      chk("hold row_data", {22'b0, row_data}, {22'b0, val[15]});
      chk("hold signature", {16'b0, signature}, {16'b0, sig_m});
      if (s.mode == 0) chk("zero signature", {16'b0, signature}, 0);
`ifdef BB_COMPARE_EN
      chk("mismatch_cnt", {27'b0, mismatch_cnt}, 32'(exp_mis));
`endif
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         #1;
         chk("mem readback", {22'b0, rd_data}, {22'b0, val[a]});
      end
   endtask

   scen_t   scen [7];
   rd_vec_t rdv  [16];

   initial begin
      scen[0] = '{0, -1, -1, 1'b0};
      scen[1] = '{1, -1, -1, 1'b1};
      scen[2] = '{2, -1, -1, 1'b0};
      scen[3] = '{2, 45, -1, 1'b0};   // stray start while row 7 settles
      scen[4] = '{2, LAST, -1, 1'b0}; // stray start in DONE
      scen[5] = '{2, -1, 57, 1'b0};   // reset during row 9 settle
      scen[6] = '{2, -1, -1, 1'b0};
      for (int i = 0; i < 16; i++) rdv[i] = '{4'(i), 10'(i)};

      rst = 1'b1; start = 1'b0; f_tb = 10'h0; loop = 1'b0; bad_en = 1'b0; rd_addr = 4'd0;
      for (int i = 0; i < 16; i++) val[i] = 10'h0;
      repeat (2) @(posedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int s = 0; s < 7; s++) begin
         run_sweep(scen[s]);
         if (scen[s].mode == 1) begin
            for (int i = 0; i < 16; i++) begin
               rd_addr = rdv[i].addr;
               #1;
               chk("loopback rd", {22'b0, rd_data}, {22'b0, rdv[i].exp});
            end
         end
      end

      // Noise during settle, fixed value only in the sample cycle of row 0.
      @(negedge clk);
      start = 1'b1;
      loop  = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= P; n++) begin
         @(negedge clk);
         f_tb = (n == P) ? 10'h2A5 : ((n % 2) ? 10'h15A : 10'h3FF);
         @(posedge clk);
      end
      #1;
      chk("glitch row_valid", {31'b0, row_valid}, 1);
      chk("glitch row_data", {22'b0, row_data}, 32'h2A5);
      chk("glitch signature", {16'b0, signature}, 32'h2A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/breadboard_sweep.md
BREADBOARD_SWEEP -- requirements
Module: breadboard_sweep

Interface
REQ-001 Parameter SETTLE, default 5, number of clock cycles {w,x,y,z} SHALL be held before f is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a 16-row sweep.
REQ-005 w, x, y, z  output  1 each  stimulus to device under test; {w,x,y,z} = current row index, w = MSB.
REQ-006 f  input  10  device response; f[n] is output fn of the device (f0..f9).
REQ-007 busy  output  1  sweep in progress.
REQ-008 done  output  1  one-cycle pulse when row 15 has been captured.
REQ-009 row_valid  output  1  one-cycle pulse per captured row.
REQ-010 row_idx  output  4  index of the row carried by row_data.
REQ-011 row_data  output  10  f value captured for row_idx.
REQ-012 signature  output  16  running response signature.
REQ-013 rd_addr  input  4  capture-memory read address; rd_data  output  10  combinational read of capture memory.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE + start=1: idx<=0, {w,x,y,z}<=0, settle counter<=0, signature<=0, busy<=1, go to SETTLE.
REQ-016 SETTLE: counter increments each cycle; on counter==SETTLE-1, go to SAMPLE.
REQ-017 SAMPLE: mem[idx]<=f, row_valid<=1, row_idx<=idx, row_data<=f, signature<={signature[14:0],signature[15]} ^ {6'b0,f}.
REQ-018 SAMPLE with idx<15: idx<=idx+1, {w,x,y,z}<=idx+1, counter<=0, go to SETTLE; each row SHALL be driven for exactly SETTLE+1 cycles.
REQ-019 SAMPLE with idx==15: {w,x,y,z} holds 15, go to DONE; DONE: done<=1, busy<=0, go to IDLE.
REQ-020 row k row_valid SHALL assert (SETTLE+1)*(k+1) cycles after the start-accepting edge; done SHALL assert 16*(SETTLE+1)+1 cycles after it.
REQ-021 start while busy or in DONE SHALL be ignored; no restart, no second done.
REQ-022 f is sampled only in SAMPLE; changes during SETTLE SHALL NOT affect capture or signature.
REQ-023 row_data, row_idx, signature and memory SHALL hold their values after done until next accepted start (memory and row outputs are overwritten only as rows are captured).
REQ-024 idx SHALL NOT wrap past 15; exactly 16 rows per sweep.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, idx 0, w=x=y=z=0, busy 0, done 0, row_valid 0, row_idx 0, row_data 0, signature 0, all 16 memory entries 0.
REQ-026 rst mid-sweep SHALL abort with no done pulse; first start after rst release SHALL run a complete sweep.

Configuration
REQ-027 Macro BB_COMPARE_EN defined: add input exp_data[9:0] (expected f for current row, presented by environment indexed by {w,x,y,z}) and output mismatch_cnt[4:0]; cleared on rst and on accepted start; incremented in SAMPLE when f!=exp_data; saturates at 16.
REQ-028 Macro BB_COMPARE_EN undefined: exp_data and mismatch_cnt ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 SETTLE=5, f tied 0, start pulse -> row_valid for idx 0..15, row_data 0, done 97 cycles after start edge, signature 16'h0000.
REQ-030 Loopback f={6'b0,w,x,y,z} -> row_data==row_idx each row; after done rd_data==rd_addr for rd_addr 0..15; w..z each value held 6 cycles.
REQ-031 start re-pulsed while row 7 settling -> ignored; idx continues 8..15; exactly one done at cycle 97.
REQ-032 rst pulsed during row 9 SETTLE -> all outputs 0 same cycle, rd_data 0 for all addresses, no done; next start yields full 16-row sweep.
REQ-033 f toggled every cycle during SETTLE, stable value 10'h2A5 in SAMPLE cycle -> captured row_data 10'h2A5.
REQ-034 BB_COMPARE_EN, exp_data = loopback except row 3 expects 10'h000 vs f 10'h003 -> mismatch_cnt=1 after done.
